// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner:
// segment table, cathode bit positions and the per-digit configuration payload.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CT_W  = 8;
  localparam int unsigned CT_A  = 0;
  localparam int unsigned CT_G  = 6;
  localparam int unsigned CT_DP = 7;

  // Active-low a..g patterns indexed by hex value (bit 0 = a).
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic       blank;
  } digit_cfg_t;

  localparam digit_cfg_t CFG_RESET = '{digit: 4'h0, dp: 1'b0, blank: 1'b1};

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low a..g segment decode.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[hex];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment display driver with frame-synchronous
// (tear-free) content update, leading-zero suppression and PWM dimming.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 60,
  parameter int unsigned DIGIT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [CT_W-1:0]         CT,
  output logic                    frame_done
);

  localparam int unsigned SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (DIGIT_CYCLES < 16) begin : g_bad_digit_cycles
    $error("seven_seg_scanner: DIGIT_CYCLES must be at least 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_seg_scanner: NUM_DIGITS must be in 1..8");
  end

  logic [SLOT_W-1:0] slot_q, slot_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic [3:0]        pwm_q, pwm_nxt;

  digit_cfg_t [NUM_DIGITS-1:0] load_cfg;
  digit_cfg_t [NUM_DIGITS-1:0] pend_q, pend_nxt;
  digit_cfg_t [NUM_DIGITS-1:0] act_q, act_nxt;
  logic                        lz_pend_q, lz_pend_nxt;
  logic                        lz_act_q, lz_act_nxt;

  logic                  frame_end;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] dark;
  digit_cfg_t            sel;
  logic [SEG_W-1:0]      seg_c;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [CT_W-1:0]       ct_nxt;
  logic                  fd_nxt;

  // Counters, pending/active promotion and next-cycle digit selection.
  always_comb begin
    slot_nxt    = slot_q + SLOT_W'(1);
    idx_nxt     = idx_q;
    pwm_nxt     = pwm_q + 4'd1;
    load_cfg    = '0;
    pend_nxt    = pend_q;
    lz_pend_nxt = lz_pend_q;
    act_nxt     = act_q;
    lz_act_nxt  = lz_act_q;
    zero_run    = 1'b1;
    dark        = '0;

    frame_end = (slot_q == SLOT_LAST) && (idx_q == IDX_LAST);

    if (slot_q == SLOT_LAST) begin
      slot_nxt = '0;
      idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      load_cfg[k] = '{digit: digits[4*k +: 4], dp: dp[k], blank: blank[k]};
    end

    if (load) begin
      pend_nxt    = load_cfg;
      lz_pend_nxt = lz_en;
    end

    // A load landing on the frame's last cycle is promoted directly.
    if (frame_end) begin
      act_nxt    = pend_nxt;
      lz_act_nxt = lz_pend_nxt;
    end

    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_nxt[k].digit == 4'h0);
      dark[k]  = act_nxt[k].blank || (lz_act_nxt && (k > 0) && zero_run);
    end

    sel = act_nxt[idx_nxt];
  end

  seven_seg_decoder u_decoder (
    .hex   (sel.digit),
    .seg_c (seg_c)
  );

  // Output image for the upcoming cycle. PWM is gated on its pre-increment
  // value so the slot-0 guard never swallows a duty step (level 0 = 1/16).
  always_comb begin
    an_nxt = '1;
    ct_nxt = '1;
    fd_nxt = (slot_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);
    lit    = (slot_nxt != '0) && !dark[idx_nxt] && (pwm_q <= brightness);

    if (lit) begin
      an_nxt              = ~(NUM_DIGITS'(1) << idx_nxt);
      ct_nxt[CT_G:CT_A]   = seg_c;
      ct_nxt[CT_DP]       = ~sel.dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      pend_q     <= {NUM_DIGITS{CFG_RESET}};
      act_q      <= {NUM_DIGITS{CFG_RESET}};
      lz_pend_q  <= 1'b0;
      lz_act_q   <= 1'b0;
      AN         <= '1;
      CT         <= '1;
      frame_done <= 1'b0;
    end else begin
      slot_q     <= slot_nxt;
      idx_q      <= idx_nxt;
      pwm_q      <= pwm_nxt;
      pend_q     <= pend_nxt;
      act_q      <= act_nxt;
      lz_pend_q  <= lz_pend_nxt;
      lz_act_q   <= lz_act_nxt;
      AN         <= an_nxt;
      CT         <= ct_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000, clock frequency in Hz.
REQ-003 SHALL have parameter REFRESH_HZ, default 60, full-frame refresh rate in Hz.
REQ-004 SHALL have parameter DIGIT_CYCLES, default CLK_HZ/(REFRESH_HZ*NUM_DIGITS), clocks per digit slot, elaboration error if < 16.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port digits, input, NUM_DIGITS x 4, hex nibble per digit, index 0 = rightmost.
REQ-008 SHALL have port dp, input, NUM_DIGITS, decimal-point enable per digit.
REQ-009 SHALL have port blank, input, NUM_DIGITS, force digit dark.
REQ-010 SHALL have port lz_en, input, 1, leading-zero suppression enable.
REQ-011 SHALL have port brightness, input, 4, duty level, 0 = 1/16, 15 = full.
REQ-012 SHALL have port load, input, 1, one-cycle strobe capturing digits/dp/blank/lz_en.
REQ-013 SHALL have port AN, output, NUM_DIGITS, anode selects, active-low.
REQ-014 SHALL have port CT, output, 8, cathodes active-low, bit 0..6 = a..g, bit 7 = DP.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at end of each frame.

Function
REQ-016 SHALL run slot counter 0..DIGIT_CYCLES-1; at DIGIT_CYCLES-1 SHALL wrap to 0 and advance digit index.
REQ-017 Digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; NUM_DIGITS=1 holds index 0.
REQ-018 frame_done SHALL be 1 exactly in the cycle where slot counter = DIGIT_CYCLES-1 and index = NUM_DIGITS-1.
REQ-019 load SHALL copy inputs into a pending register; pending copies into the active register in the cycle frame_done is 1; load in that same cycle SHALL be the value promoted.
REQ-020 Multiple loads within one frame SHALL keep only the last; no load leaves the active register unchanged.
REQ-021 Active register SHALL change only at frame boundaries (tear-free display).
REQ-022 brightness SHALL be sampled live (not buffered).
REQ-023 A free-running 4-bit pwm counter SHALL increment every clock; digit lit only while pwm <= brightness.
REQ-024 SHALL drive AN all-ones during slot counter = 0 (ghosting guard) regardless of other inputs.
REQ-025 Otherwise AN SHALL drive low only bit [index] when lit, all-ones when dark.
REQ-026 Digit k SHALL be dark if blank[k], or if lz_en and k > 0 and digits[j] = 0 for all j >= k (active register).
REQ-027 CT[6:0] SHALL be hex decode of active digits[index]: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E (CT[7]=1 shown).
REQ-028 CT[7] SHALL be ~dp[index]; CT SHALL be FF whenever AN is all-ones.
REQ-029 AN, CT SHALL be registered and update on the same edge as index; never pair AN of digit k with CT of another digit.
REQ-030 Output latency from index change to AN/CT SHALL be 0 cycles relative to the registered index (next-state computed combinationally).

Reset
REQ-031 While rst=1 at a clock edge: AN=all-ones, CT=FF, frame_done=0, index=0, slot and pwm counters=0.
REQ-032 Reset SHALL set active and pending registers to digits=0, dp=0, blank=all-ones, lz_en=0, so the display is dark until first promoted load.
REQ-033 Reset asserted mid-frame SHALL discard pending load; after release the first frame starts at index 0, slot 0.

Structure
REQ-034 Package seven_seg_pkg SHALL hold the 16-entry segment table constant, the CT bit-position constants, and a digit-config struct typedef (digit, dp, blank).
REQ-035 Hex-to-segment decode SHALL be sub-module seven_seg_decoder (combinational, 4-bit in, 7-bit active-low out).

Verification (NUM_DIGITS=4, DIGIT_CYCLES=16)
REQ-036 Reset, no load -> AN=F and CT=FF for 3 full frames; frame_done every 64 cycles.
REQ-037 load digits=4'h1,2,3,4 (idx3..0), brightness=15 -> next frame AN sequence E,D,B,7 with CT 99,B0,A4,F9; AN=F on each slot cycle 0.
REQ-038 load digits 0,0,5,0 with lz_en=1 -> idx3,2 dark (AN=F); idx1 CT=92; idx0 CT=C0 lit.
REQ-039 Load 1111 mid-frame then load 2222 same frame -> current frame unchanged, next frame shows all 2 (CT=A4); no 1 ever appears.
REQ-040 brightness=3, dp=4'b0001 -> each slot digit lit 4 of every 16 pwm counts; idx0 CT bit7=0.
REQ-041 rst pulsed at idx 2 slot 7 with pending load -> next cycle AN=F, CT=FF, dark until new load promoted.
